// File: rtl/rsa_word_packer.sv
// Packs DW-bit ingress words into one OW-bit operand for the RSA core, then drains the result as DW-bit words.
// Latency 1 cycle per phase change; all valid/ready outputs are registered from state, so upstream stalls simply hold.
module rsa_word_packer #(
   parameter int DW = 32,
   parameter int NW = 64,
   localparam int OW = DW * NW,
   localparam int CW = (NW > 1) ? $clog2(NW) : 1
) (
   input  logic          HCLK,
   input  logic          HRESET,
   input  logic          clear,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          op_valid,
   input  logic          op_ready,
   output logic [OW-1:0] op_data,
   input  logic          res_valid,
   output logic          res_ready,
   input  logic [OW-1:0] res_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic [1:0]    state,
   output logic [CW-1:0] word_cnt
);

   typedef enum logic [1:0] {LOAD = 2'd0, SEND = 2'd1, WAIT = 2'd2, DRAIN = 2'd3} state_t;

   state_t        cur, nxt;
   logic [OW-1:0] data_buf;
   logic [CW-1:0] cnt;
   logic          in_xfer, op_xfer, res_xfer, out_xfer, cnt_last;
   logic          in_ready_nxt, op_valid_nxt, res_ready_nxt, out_valid_nxt;

   assign in_xfer  = in_valid  & in_ready;
   assign op_xfer  = op_valid  & op_ready;
   assign res_xfer = res_valid & res_ready;
   assign out_xfer = out_valid & out_ready;
   assign cnt_last = (cnt == CW'(NW - 1));

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) cur <= LOAD;
      else        cur <= nxt;
   end

   always_comb begin
      nxt = cur;
      if (clear) begin
         nxt = LOAD;
      end else begin
         unique case (cur)
            LOAD:  if (in_xfer && cnt_last)  nxt = SEND;
            SEND:  if (op_xfer)              nxt = WAIT;
            WAIT:  if (res_xfer)             nxt = DRAIN;
            DRAIN: if (out_xfer && cnt_last) nxt = LOAD;
         endcase
      end
   end

   // Handshake flags are decoded from the next state and registered, keeping inputs off every valid/ready path.
   always_comb begin
      in_ready_nxt  = (nxt == LOAD);
      op_valid_nxt  = (nxt == SEND);
      res_ready_nxt = (nxt == WAIT);
      out_valid_nxt = (nxt == DRAIN);
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         in_ready  <= 1'b0;
         op_valid  <= 1'b0;
         res_ready <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         in_ready  <= in_ready_nxt;
         op_valid  <= op_valid_nxt;
         res_ready <= res_ready_nxt;
         out_valid <= out_valid_nxt;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         data_buf <= '0;
         cnt      <= '0;
      end else if (clear) begin
         data_buf <= '0;
         cnt      <= '0;
      end else begin
         unique case (cur)
            LOAD: if (in_xfer) begin
               data_buf <= {in_data, data_buf[OW-1:DW]};
               cnt      <= cnt_last ? '0 : cnt + CW'(1);
            end
            SEND: ;
            WAIT: if (res_xfer) data_buf <= res_data;
            DRAIN: if (out_xfer) begin
               data_buf <= {{DW{1'b0}}, data_buf[OW-1:DW]};
               cnt      <= cnt_last ? '0 : cnt + CW'(1);
            end
         endcase
      end
   end

   assign op_data  = data_buf;
   assign out_data = data_buf[DW-1:0];
   assign out_last = (cur == DRAIN) && cnt_last;
   assign state    = cur;
   assign word_cnt = cnt;

endmodule

// File: tb/tb_rsa_word_packer.sv
// Directed and random-stall bench for rsa_word_packer at DW=32, NW=64.
module tb_rsa_word_packer;
   localparam int DW = 32;
   localparam int NW = 64;
   localparam int OW = DW * NW;

   logic          HCLK = 1'b0;
   logic          HRESET = 1'b0;
   logic          clear, in_valid, in_ready, op_valid, op_ready;
   logic          res_valid, res_ready, out_valid, out_ready, out_last;
   logic [DW-1:0] in_data, out_data;
   logic [OW-1:0] op_data, res_data;
   logic [1:0]    state;
   logic [5:0]    word_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int          widx;
      logic [31:0] exp;
   } vec_t;
   vec_t vtab[6];

   logic [OW-1:0] exp_op, exp_res;

   rsa_word_packer #(.DW(DW), .NW(NW)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .state(state), .word_cnt(word_cnt)
   );

   always #5 HCLK = ~HCLK;

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_wide(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      int bad = -1;
      for (int i = NW - 1; i >= 0; i--)
         if (act[32*i +: 32] !== exp[32*i +: 32]) bad = i;
      n_tests++;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL %s: word %0d got 0x%08h, expected 0x%08h", nm, bad, act[32*bad +: 32], exp[32*bad +: 32]);
      end
   endtask

   // Consumes one full result; every accepted word must be the next expected one.
   task automatic drain(input string nm, input logic [OW-1:0] exp, input bit toggle);
      int idx = 0;
      for (int cyc = 0; cyc < 1000 && idx < NW; cyc++) begin
         out_ready = toggle ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         res_valid = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            chk($sformatf("%s_data%0d", nm, idx), 64'(out_data), 64'(exp[32*idx +: 32]));
            chk($sformatf("%s_last%0d", nm, idx), 64'(out_last), 64'(idx == NW - 1));
            idx++;
         end
         tick();
      end
      out_ready = 1'b0;
      res_valid = 1'b0;
      chk({nm, "_count"}, 64'(idx), 64'(NW));
      chk({nm, "_state_end"}, 64'(state), 64'd0);
      chk({nm, "_in_ready_end"}, 64'(in_ready), 64'd1);
   endtask

   task automatic load_seq(input logic [31:0] base);
      for (int i = 0; i < NW; i++) begin
         in_valid = 1'b1;
         in_data  = base + 32'(i);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic run_op(input int n);
      logic [OW-1:0] eo, er;
      int k = 0;
      int cyc;
      bit done;
      for (int i = 0; i < NW; i++) begin
         eo[32*i +: 32] = $urandom;
         er[32*i +: 32] = $urandom;
      end
      res_data = er;
      for (cyc = 0; cyc < 2000 && k < NW; cyc++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = eo[32*k +: 32];
         res_valid = 1'($urandom_range(0, 1));
         op_ready  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         if (in_valid && in_ready) k++;
         tick();
      end
      in_valid = 1'b1;
      in_data  = 32'hFFFF_FFFF;
      chk($sformatf("rnd%0d_load_done", n), 64'(k), 64'(NW));
      chk($sformatf("rnd%0d_state_send", n), 64'(state), 64'd1);
      chk_wide($sformatf("rnd%0d_operand", n), op_data, eo);
      done = 0;
      for (cyc = 0; cyc < 200 && !done; cyc++) begin
         op_ready  = 1'($urandom_range(0, 1));
         res_valid = 1'($urandom_range(0, 1));
         if (op_ready && op_valid) done = 1;
         tick();
      end
      op_ready = 1'b0;
      chk($sformatf("rnd%0d_state_wait", n), 64'(state), 64'd2);
      done = 0;
      for (cyc = 0; cyc < 200 && !done; cyc++) begin
         res_valid = 1'($urandom_range(0, 1));
         if (res_valid && res_ready) done = 1;
         tick();
      end
      res_valid = 1'b0;
      in_valid  = 1'b0;
      chk($sformatf("rnd%0d_state_drain", n), 64'(state), 64'd3);
      drain($sformatf("rnd%0d", n), er, 1'b0);
   endtask

   always @(negedge HCLK) begin
      if (HRESET === 1'b0) begin
         n_tests++;
         if ($countones({in_ready, op_valid, res_ready, out_valid}) > 1) begin
            n_fail++;
            $display("FAIL excl: in_ready=%b op_valid=%b res_ready=%b out_valid=%b, expected at most one set",
                     in_ready, op_valid, res_ready, out_valid);
         end
      end
   end

   initial begin
      vtab[0] = '{0,  32'h0000_0000};
      vtab[1] = '{1,  32'h0000_0001};
      vtab[2] = '{17, 32'h0000_0011};
      vtab[3] = '{32, 32'h0000_0020};
      vtab[4] = '{62, 32'h0000_003E};
      vtab[5] = '{63, 32'h0000_003F};

      clear = 0; in_valid = 0; in_data = '0; op_ready = 0;
      res_valid = 0; res_data = '0; out_ready = 0;

      // Reset state
      #1 HRESET = 1'b1;
      #11;
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_word_cnt", 64'(word_cnt), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_flags", 64'({op_valid, res_ready, out_valid, out_last}), 64'd0);
      chk_wide("rst_op_data", op_data, '0);
      #6 HRESET = 1'b0;
      #2 chk("in_ready_before_edge", 64'(in_ready), 64'd0);
      tick();
      chk("in_ready_after_edge", 64'(in_ready), 64'd1);

      // Back-to-back load of 0..63
      for (int i = 0; i < NW; i++) begin
         in_valid = 1'b1;
         in_data  = 32'(i);
         exp_op[32*i +: 32] = 32'(i);
         tick();
         if (i == NW - 2) chk("op_valid_before_last", 64'(op_valid), 64'd0);
      end
      chk("op_valid_after_last", 64'(op_valid), 64'd1);
      chk("in_ready_in_send", 64'(in_ready), 64'd0);
      chk("state_send", 64'(state), 64'd1);
      chk("word_cnt_wrap", 64'(word_cnt), 64'd0);
      for (int v = 0; v < 6; v++)
         chk($sformatf("op_word%0d", vtab[v].widx), 64'(op_data[32*vtab[v].widx +: 32]), 64'(vtab[v].exp));

      // Backpressure with stray input words and stray results
      in_valid = 1'b1; in_data = 32'hBAD0_0000;
      res_valid = 1'b1; res_data = {NW{32'h5A5A_5A5A}};
      for (int c = 0; c < 10; c++) begin
         tick();
         chk($sformatf("bp_op_valid%0d", c), 64'(op_valid), 64'd1);
         chk_wide($sformatf("bp_op_data%0d", c), op_data, exp_op);
      end
      in_valid = 1'b0; res_valid = 1'b0;
      op_ready = 1'b1;
      tick();
      op_ready = 1'b0;
      chk("state_wait", 64'(state), 64'd2);
      chk("res_ready_wait", 64'(res_ready), 64'd1);
      chk("op_valid_wait", 64'(op_valid), 64'd0);
      repeat (3) tick();
      chk("wait_holds", 64'(state), 64'd2);

      // Result capture and toggled drain
      for (int i = 0; i < NW; i++) exp_res[32*i +: 32] = 32'hA500_0000 + 32'(i);
      res_data  = exp_res;
      res_valid = 1'b1;
      tick();
      res_valid = 1'b0;
      chk("state_drain", 64'(state), 64'd3);
      chk("out_valid_drain", 64'(out_valid), 64'd1);
      chk("out_data_first", 64'(out_data), 64'hA500_0000);
      chk("out_last_first", 64'(out_last), 64'd0);
      drain("drain", exp_res, 1'b1);

      // Abort: 20 words, then clear coincident with a presented word
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h100 + 32'(i);
         tick();
      end
      in_data = 32'h0000_DEAD;
      clear   = 1'b1;
      tick();
      clear = 1'b0; in_valid = 1'b0;
      chk("clr_word_cnt", 64'(word_cnt), 64'd0);
      chk("clr_state", 64'(state), 64'd0);
      chk("clr_in_ready", 64'(in_ready), 64'd1);
      chk_wide("clr_buf", op_data, '0);
      load_seq(32'h200);
      for (int i = 0; i < NW; i++) exp_op[32*i +: 32] = 32'h200 + 32'(i);
      chk("clr_state_send", 64'(state), 64'd1);
      chk("clr_word0", 64'(op_data[31:0]), 64'h200);
      chk_wide("clr_operand", op_data, exp_op);

      // Async reset in the middle of a drain
      op_ready = 1'b1;
      tick();
      op_ready  = 1'b0;
      res_data  = exp_res;
      res_valid = 1'b1;
      tick();
      res_valid = 1'b0;
      out_ready = 1'b1;
      repeat (30) tick();
      out_ready = 1'b0;
      chk("mid_drain_cnt", 64'(word_cnt), 64'd30);
      chk("mid_drain_valid", 64'(out_valid), 64'd1);
      #2 HRESET = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_state", 64'(state), 64'd0);
      chk("arst_word_cnt", 64'(word_cnt), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd0);
      #2 HRESET = 1'b0;
      tick();
      chk("arst_release_in_ready", 64'(in_ready), 64'd1);
      chk("arst_release_out_valid", 64'(out_valid), 64'd0);
      chk("arst_release_state", 64'(state), 64'd0);

      // Three random-stall operations
      for (int n = 0; n < 3; n++) run_op(n);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rsa_word_packer.md
RSA_WORD_PACKER -- requirements
Module: rsa_word_packer

Interface
REQ-001 SHALL have parameter DW, default 32, meaning bus word width in bits.
REQ-002 SHALL have parameter NW, default 64, meaning words per operand (operand width OW = DW*NW = 2048).
REQ-003 SHALL have port HCLK, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port HRESET, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port clear, input, 1, synchronous abort to LOAD.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DW): the word ingress from the AHB register front-end.
REQ-007 SHALL have ports op_valid (output, 1), op_ready (input, 1) and op_data (output, OW): the assembled operand to the RSA core.
REQ-008 SHALL have ports res_valid (input, 1), res_ready (output, 1) and res_data (input, OW): the result from the RSA core.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, DW) and out_last (output, 1): the word egress back to the front-end.
REQ-010 SHALL have ports state (output, 2), the FSM state, and word_cnt (output, log2(NW)), the current word index.

Function
REQ-011 SHALL implement four states: LOAD=0, SEND=1, WAIT=2, DRAIN=3.
REQ-012 SHALL hold a single OW-bit buffer buf; op_data = buf continuously.
REQ-013 LOAD: in_ready=1; a transfer occurs when in_valid&in_ready; on transfer buf <= {in_data, buf[OW-1:DW]} and word_cnt increments.
REQ-014 SHALL make the first accepted word the least-significant word, so that after NW words word k sits in buf[DW*k+DW-1 : DW*k].
REQ-015 When the transfer with word_cnt==NW-1 occurs, SHALL set word_cnt to 0 (wrap) and go to SEND on the next cycle.
REQ-016 SEND: op_valid=1, in_ready=0; buf and op_valid SHALL hold stable until op_ready; the cycle op_valid&op_ready is seen goes to WAIT.
REQ-017 WAIT: res_ready=1; on res_valid&res_ready, buf <= res_data and the next state is DRAIN; otherwise the block stays in WAIT indefinitely.
REQ-018 DRAIN: out_valid=1, out_data=buf[DW-1:0], out_last=(word_cnt==NW-1).
REQ-019 In DRAIN, on out_valid&out_ready SHALL shift buf right by DW (zero fill) and increment word_cnt; out_data SHALL stay stable while out_ready=0.
REQ-020 After the last-word transfer SHALL wrap word_cnt to 0 and return to LOAD.
REQ-021 SHALL register every handshake output from state only, with no combinational path from any input to any valid/ready output.
REQ-022 in_ready, op_valid, res_ready and out_valid SHALL be mutually exclusive; at most one is 1 in any cycle.
REQ-023 Words presented while not in LOAD SHALL not be accepted; the sender holds them.
REQ-024 A res_valid arriving outside WAIT SHALL be ignored, since res_ready=0.
REQ-025 clear SHALL take priority over every handshake in the same cycle: next state LOAD, word_cnt=0, buf=0, and the coincident transfer discarded.
REQ-026 Throughput SHALL be one word per cycle in LOAD and DRAIN under continuous valid/ready.
REQ-027 Latency SHALL be: last input word -> op_valid in 1 cycle; result capture -> out_valid in 1 cycle.

Reset
REQ-028 When HRESET is asserted SHALL set, asynchronously: state=LOAD, word_cnt=0, buf=0, op_valid=0, res_ready=0, out_valid=0, out_last=0, in_ready=0.
REQ-029 in_ready SHALL rise on the first HCLK edge after HRESET deasserts.
REQ-030 HRESET asserted mid-SEND, WAIT or DRAIN SHALL abandon the operation; no partial output appears after release.

Verification
REQ-031 Load: 64 words 0x00000000..0x0000003F back-to-back -> op_valid asserts exactly 1 cycle after the 64th word, op_data[31:0]=0x0, op_data[2047:2016]=0x3F; in_ready=0 from that cycle.
REQ-032 Backpressure: op_ready held 0 for 10 cycles -> op_data is unchanged and op_valid stays 1; op_ready=1 -> state=WAIT next cycle, res_ready=1.
REQ-033 Result drain: res_data = word k equal to 0xA5000000+k -> out_data sequence 0xA5000000..0xA500003F, out_last only on 0xA500003F; with out_ready toggling 1/0 each cycle, no word is lost or duplicated.
REQ-034 Abort: clear pulsed after 20 input words with in_valid=1 in the same cycle -> that word is dropped; the next 64 words form the operand, whose word 0 is the first post-clear word.
REQ-035 Async reset: HRESET asserted in DRAIN at word_cnt=30, between clock edges -> out_valid=0 immediately, state=0, word_cnt=0; after release in_ready=1 on the next edge.
REQ-036 Exclusivity: a random-stall run of 3 full operations -> an assertion checks that at most one of in_ready/op_valid/res_ready/out_valid is 1 every cycle, and that res_valid outside WAIT never changes buf.
